// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Data-side load/store engine of the RV32I core. Accepts one decoded memory
//   request at a time, drives a single-port 32-bit data memory without byte
//   enables (sub-word stores are read-modify-write) and returns sign/zero
//   extended load data over a valid/ready response channel.
//
// Ports
//   clk, rstn       clock; synchronous active-low reset
//   req_*           request channel (valid/ready, we, size, unsigned, addr,
//                   wdata); fields are latched on acceptance
//   rsp_*           response channel (valid/ready, rdata, err)
//   mem_*           data memory port; mem_rdata is valid one cycle after a
//                   read cycle
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] word_addr_q;
   logic [1:0]            lane_q;
   logic [1:0]            size_q;
   logic                  unsigned_q;
   logic                  we_q;
   logic [15:0]           wdata_q;     // only the low half is ever merged
   logic [31:0]           word_q;      // full store word / merged RMW word
   logic [31:0]           rdata_q;
   logic                  err_q;

   // Byte-address bits above the memory size alias; they are intentionally dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

   function automatic logic req_error(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_WORD: return lane != 2'b00;
         SZ_HALF: return lane[0];
         SZ_BYTE: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   // Little-endian lane select followed by sign or zero extension.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return word;
      endcase
   endfunction

   // Replace only the addressed lane; the other lanes keep the value read back.
   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic [15:0] data);
      logic [31:0] w;
      w = word;
      if (size == SZ_BYTE)
         w[{lane, 3'b000} +: 8] = data[7:0];
      else if (lane[1])
         w[31:16] = data;
      else
         w[15:0] = data;
      return w;
   endfunction

   // NOTE: reset is sampled on the clock edge (synchronous), and every register,
   // including the data words, is cleared so the outputs come up as zeros.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         word_addr_q <= '0;
         lane_q      <= '0;
         size_q      <= '0;
         unsigned_q  <= 1'b0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         word_q      <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  word_addr_q <= req_addr[ADDR_WIDTH+1:2];
                  lane_q      <= req_addr[1:0];
                  size_q      <= req_size;
                  unsigned_q  <= req_unsigned;
                  we_q        <= req_we;
                  wdata_q     <= req_wdata[15:0];
                  rdata_q     <= '0;
                  err_q       <= req_error(req_size, req_addr[1:0]);
                  if (req_error(req_size, req_addr[1:0])) begin
                     state_q <= RESP;
                  end else if (!req_we || req_size != SZ_WORD) begin
                     state_q <= RD;
                  end else begin
                     word_q  <= req_wdata;
                     state_q <= WR;
                  end
               end
            end
            RD:  state_q <= CAP;
            // mem_rdata is valid in this cycle: the read was issued in RD.
            CAP: begin
               if (we_q) begin
                  word_q  <= store_merge(mem_rdata, size_q, lane_q, wdata_q);
                  state_q <= WR;
               end else begin
                  word_q  <= mem_rdata;
                  rdata_q <= load_extend(mem_rdata, size_q, lane_q, unsigned_q);
                  state_q <= RESP;
               end
            end
            WR: begin
               rdata_q <= '0;
               err_q   <= 1'b0;
               state_q <= RESP;
            end
            RESP: if (rsp_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Moore outputs: decoded from state and registered data only.
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign mem_en    = (state_q == RD) || (state_q == WR);
   assign mem_we    = (state_q == WR);
   assign mem_addr  = word_addr_q;
   assign mem_wdata = (state_q == WR) ? word_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [1:0]    req_size = 2'b00;
   logic          req_unsigned = 1'b0;
   logic [31:0]   req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = '0;

   mem_access_unit #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port memory with one-cycle read latency, plus a preload port.
   logic [31:0]   mem [0:(1<<AW)-1];
   logic          pre_en = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [31:0]   pre_data = '0;

   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
   end

   // Access monitor: running counts and the last write seen.
   int            cyc = 0, n_rd = 0, n_wr = 0, wr_cyc = 0;
   logic [AW-1:0] rd_addr = '0, wr_addr = '0;
   logic [31:0]   wr_data = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_en && !mem_we) begin
         n_rd    <= n_rd + 1;
         rd_addr <= mem_addr;
      end
      if (mem_en && mem_we) begin
         n_wr    <= n_wr + 1;
         wr_addr <= mem_addr;
         wr_data <= mem_wdata;
         wr_cyc  <= cyc;
      end
   end

   int tests = 0;
   int fails = 0;
   int t_cyc, base_rd, base_wr, lat;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   // Present a request, note the accept edge, scramble the inputs, then wait
   // (bounded) for rsp_valid. lat = cycles after the accept edge.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      base_rd = n_rd; base_wr = n_wr;
      @(posedge clk);
      t_cyc = cyc;
      #1;
      req_valid = 1'b0; req_we = ~we; req_size = 2'b11; req_unsigned = ~uns;
      req_addr = 32'h0000_0FFF; req_wdata = 32'hFFFF_FFFF;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                         input int exp_rd, input int exp_wr);
      issue(we, size, uns, addr, wdata);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_rdata"}, rsp_rdata, exp_data);
      check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
      check({tag, "_nrd"}, n_rd - base_rd, exp_rd);
      check({tag, "_nwr"}, n_wr - base_wr, exp_wr);
      @(posedge clk); #1;
      check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] hold_data;

      // Reset held for two edges
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      check("rst_mem_en", {31'b0, mem_en}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      rstn = 1'b1;

      // Loads from word 3 = 0x8899AABB
      preload(10'd3, 32'h8899_AABB);
      run_op("lb", 1'b0, 2'b10, 1'b0, 32'h0D, 32'h0, 3, 32'hFFFF_FFAA, 1'b0, 1, 0);
      check("lb_rd_addr", {22'b0, rd_addr}, 32'd3);
      run_op("lbu", 1'b0, 2'b10, 1'b1, 32'h0D, 32'h0, 3, 32'h0000_00AA, 1'b0, 1, 0);
      run_op("lh", 1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 3, 32'hFFFF_8899, 1'b0, 1, 0);
      run_op("lhu", 1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 3, 32'h0000_8899, 1'b0, 1, 0);
      run_op("lw", 1'b0, 2'b00, 1'b0, 32'h0C, 32'h0, 3, 32'h8899_AABB, 1'b0, 1, 0);
      run_op("lbu3", 1'b0, 2'b10, 1'b1, 32'h0F, 32'h0, 3, 32'h0000_0088, 1'b0, 1, 0);
      // Address bits above the memory wrap around onto word 3
      run_op("lw_alias", 1'b0, 2'b00, 1'b0, 32'h0000_100C, 32'h0, 3, 32'h8899_AABB, 1'b0, 1, 0);
      check("lw_alias_rd_addr", {22'b0, rd_addr}, 32'd3);

      // Byte RMW
      run_op("sb", 1'b1, 2'b10, 1'b0, 32'h0E, 32'h1234_5677, 4, 32'h0, 1'b0, 1, 1);
      check("sb_wr_data", wr_data, 32'h8877_AABB);
      check("sb_wr_addr", {22'b0, wr_addr}, 32'd3);
      check("sb_wr_cyc", wr_cyc - t_cyc, 32'd3);
      check("sb_mem", mem[3], 32'h8877_AABB);

      // Half RMW
      preload(10'd3, 32'h8899_AABB);
      run_op("sh", 1'b1, 2'b01, 1'b0, 32'h0C, 32'hFFFF_1234, 4, 32'h0, 1'b0, 1, 1);
      check("sh_wr_data", wr_data, 32'h8899_1234);
      run_op("sh_hi", 1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_5A5A, 4, 32'h0, 1'b0, 1, 1);
      check("sh_hi_wr_data", wr_data, 32'h5A5A_1234);

      // Word store: no read, write on the first cycle after accept
      run_op("sw", 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 0, 1);
      check("sw_wr_data", wr_data, 32'hDEAD_BEEF);
      check("sw_wr_addr", {22'b0, wr_addr}, 32'd4);
      check("sw_wr_cyc", wr_cyc - t_cyc, 32'd1);
      run_op("lw4", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1, 0);

      // Errors: no memory traffic, response on the first cycle
      run_op("err_lw", 1'b0, 2'b00, 1'b0, 32'h0E, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      run_op("err_sh", 1'b1, 2'b01, 1'b0, 32'h0D, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, 0, 0);
      run_op("err_rsv", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      run_op("ok_after_err", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 3, 32'h0000_0034, 1'b0, 1, 0);

      // Backpressure: response held for five cycles
      rsp_ready = 1'b0;
      issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
      check("bp_lat", lat, 32'd3);
      hold_data = rsp_rdata;
      check("bp_rdata", hold_data, 32'hFFFF_BEEF);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_valid", {31'b0, rsp_valid}, 32'd1);
         check("bp_stable", rsp_rdata, hold_data);
         check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release", {31'b0, req_ready}, 32'd1);

      // Reset during CAP of a byte store: no write, back to IDLE
      preload(10'd3, 32'h8899_AABB);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h0D; req_wdata = 32'h0000_0011;
      base_wr = n_wr;
      @(posedge clk); #1;      // RD
      req_valid = 1'b0;
      @(posedge clk); #1;      // CAP
      rstn = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
      check("rst_mid_en", {31'b0, mem_en}, 32'd0);
      rstn = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_mid_nwr", n_wr - base_wr, 32'd0);
      check("rst_mid_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_mid_mem", mem[3], 32'h8899_AABB);
      run_op("post_rst_lw", 1'b0, 2'b00, 1'b0, 32'h0C, 32'h0, 3, 32'h8899_AABB, 1'b0, 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
